// File: rtl/imm_decode_stage_pkg.sv
// Shared types and opcode constants for the immediate decode stage.
package imm_decode_stage_pkg;

    // Immediate format produced by the decoder.
    typedef enum logic [2:0] {
        FMT_NONE   = 3'd0,
        FMT_I      = 3'd1,
        FMT_S      = 3'd2,
        FMT_B      = 3'd3,
        FMT_U      = 3'd4,
        FMT_J      = 3'd5,
        FMT_SHAMT  = 3'd6,
        FMT_SHAMT5 = 3'd7
    } imm_fmt_t;

    // Major opcodes (instr[6:0]) that carry or explicitly lack an immediate.
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;

    // funct3 values 001 (SLL*) and 101 (SRL*/SRA*) use a shift amount instead of an I immediate.
    function automatic logic is_shift_f3(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b101);
    endfunction

endpackage

// File: rtl/imm_decode_stage_imm_extract.sv
// Combinational immediate extraction: format classification, extension and PC-relative target.
module imm_extract
    import imm_decode_stage_pkg::*;
#(
    parameter int XLEN          = 64,
    parameter bit BYPASS_TARGET = 1'b1
) (
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output imm_fmt_t        fmt_o,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] target_o,
    output logic            illegal_o
);

    logic [6:0]             opcode;
    logic [2:0]             funct3;
    logic                   pc_rel;
    logic signed [31:0]     imm32;
    logic signed [XLEN-1:0] imm_ext;
    logic [XLEN-1:0]        target_sum;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];

    // Classify the opcode into an immediate format and flag unsupported encodings.
    always_comb begin
        fmt_o     = FMT_NONE;
        illegal_o = 1'b0;
        pc_rel    = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                if (is_shift_f3(funct3)) begin
                    fmt_o = FMT_SHAMT;
                    // RV32 shifts only have 5 shamt bits; bit 25 set is reserved.
                    if (XLEN == 32 && instr_i[25]) illegal_o = 1'b1;
                end else begin
                    fmt_o = FMT_I;
                end
            end
            OPC_OP_IMM32: begin
                fmt_o     = is_shift_f3(funct3) ? FMT_SHAMT5 : FMT_I;
                illegal_o = (XLEN == 32);
            end
            OPC_LOAD, OPC_JALR, OPC_SYSTEM: fmt_o = FMT_I;
            OPC_STORE:  fmt_o = FMT_S;
            OPC_BRANCH: begin
                fmt_o  = FMT_B;
                pc_rel = 1'b1;
            end
            OPC_LUI:    fmt_o = FMT_U;
            OPC_AUIPC: begin
                fmt_o  = FMT_U;
                pc_rel = 1'b1;
            end
            OPC_JAL: begin
                fmt_o  = FMT_J;
                pc_rel = 1'b1;
            end
            OPC_OP:     fmt_o = FMT_NONE;
            OPC_OP32: begin
                fmt_o     = FMT_NONE;
                illegal_o = (XLEN == 32);
            end
            default:    illegal_o = 1'b1;
        endcase
    end

    // Assemble the immediate as a signed 32-bit value; sign extension to XLEN follows.
    always_comb begin
        imm32 = '0;
        case (fmt_o)
            FMT_I:      imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            FMT_S:      imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            FMT_B:      imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                                 instr_i[11:8], 1'b0};
            FMT_U:      imm32 = {instr_i[31:12], 12'b0};
            FMT_J:      imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                                 instr_i[30:21], 1'b0};
            FMT_SHAMT:  imm32 = (XLEN == 64) ? {26'b0, instr_i[25:20]} : {27'b0, instr_i[24:20]};
            FMT_SHAMT5: imm32 = {27'b0, instr_i[24:20]};
            default:    imm32 = '0;
        endcase
    end

    // Signed-to-wider-signed assignment performs the sign extension (shift amounts are positive).
    assign imm_ext = imm32;
    assign imm_o   = imm_ext;

    generate
        if (BYPASS_TARGET) begin : g_target
            assign target_sum = pc_i + imm_o;
        end else begin : g_no_target
            assign target_sum = '0;
        end
    endgenerate

    // JALR is not PC-relative here (rs1 unknown), so only B/J/AUIPC get a target.
    assign target_o = pc_rel ? target_sum : '0;

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate decode stage with a 2-entry skid buffer and flush.
module imm_decode_stage
    import imm_decode_stage_pkg::*;
#(
    parameter int XLEN          = 64,
    parameter bit BYPASS_TARGET = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        imm_fmt_t        fmt;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic            illegal;
    } imm_entry_t;

    imm_entry_t dec_entry;
    imm_entry_t main_q, main_d;
    imm_entry_t skid_q, skid_d;
    logic       main_vld_q, main_vld_d;
    logic       skid_vld_q, skid_vld_d;
    logic       accept;
    logic       release_w;
    imm_fmt_t   dec_fmt;

    imm_extract #(
        .XLEN          (XLEN),
        .BYPASS_TARGET (BYPASS_TARGET)
    ) u_extract (
        .instr_i   (in_instr),
        .pc_i      (in_pc),
        .fmt_o     (dec_fmt),
        .imm_o     (dec_entry.imm),
        .target_o  (dec_entry.target),
        .illegal_o (dec_entry.illegal)
    );

    assign dec_entry.pc    = in_pc;
    assign dec_entry.instr = in_instr;
    assign dec_entry.fmt   = dec_fmt;

    // in_ready comes straight from the skid valid flop, so it is registered.
    assign in_ready  = ~skid_vld_q;
    assign accept    = in_valid & in_ready;
    assign release_w = main_vld_q & out_ready;

    // Next-state for the main/skid pair; skid is only ever occupied while main is.
    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q) begin
            if (accept) begin
                main_d     = dec_entry;
                main_vld_d = 1'b1;
            end
        end else if (!skid_vld_q) begin
            if (accept && release_w) begin
                main_d = dec_entry;
            end else if (release_w) begin
                main_vld_d = 1'b0;
            end else if (accept) begin
                skid_d     = dec_entry;
                skid_vld_d = 1'b1;
            end
        end else if (release_w) begin
            main_d     = skid_q;
            skid_vld_d = 1'b0;
        end
    end

    // State registers; reset clears data too so outputs read zero while empty after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign out_valid   = main_vld_q;
    assign out_pc      = main_q.pc;
    assign out_instr   = main_q.instr;
    assign out_fmt     = main_q.fmt;
    assign out_imm     = main_q.imm;
    assign out_target  = main_q.target;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage (XLEN=64 main instance, XLEN=32 side instance).
module tb_imm_decode_stage;

    localparam logic [2:0] F_NONE = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3,
                           F_U = 3'd4, F_J = 3'd5, F_SH = 3'd6, F_SH5 = 3'd7;
    localparam logic [31:0] SRAI63 = 32'h43F0D093;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [63:0] in_pc;
    logic [31:0] in_instr;
    logic        in_ready, out_valid, out_illegal;
    logic [63:0] out_pc, out_imm, out_target;
    logic [31:0] out_instr;
    logic [2:0]  out_fmt;

    logic        r32_in_ready, r32_out_valid, r32_out_illegal;
    logic [31:0] r32_out_pc, r32_out_imm, r32_out_target, r32_out_instr;
    logic [2:0]  r32_out_fmt;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(64), .BYPASS_TARGET(1'b1)) u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_fmt(out_fmt), .out_imm(out_imm), .out_target(out_target), .out_illegal(out_illegal)
    );

    imm_decode_stage #(.XLEN(32), .BYPASS_TARGET(1'b1)) u_dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(r32_in_ready), .in_pc(in_pc[31:0]), .in_instr(in_instr),
        .out_valid(r32_out_valid), .out_ready(out_ready), .out_pc(r32_out_pc),
        .out_instr(r32_out_instr), .out_fmt(r32_out_fmt), .out_imm(r32_out_imm),
        .out_target(r32_out_target), .out_illegal(r32_out_illegal)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic [63:0] tgt;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model_decode(input logic [63:0] pc, input logic [31:0] i);
        exp_t e;
        logic [2:0] f3;
        f3 = i[14:12];
        e.pc = pc; e.instr = i; e.fmt = F_NONE; e.imm = '0; e.tgt = '0; e.ill = 1'b0;
        case (i[6:0])
            7'h13: if (f3 == 3'd1 || f3 == 3'd5) begin
                       e.fmt = F_SH;  e.imm = {58'd0, i[25:20]};
                   end else begin
                       e.fmt = F_I;   e.imm = {{52{i[31]}}, i[31:20]};
                   end
            7'h1B: if (f3 == 3'd1 || f3 == 3'd5) begin
                       e.fmt = F_SH5; e.imm = {59'd0, i[24:20]};
                   end else begin
                       e.fmt = F_I;   e.imm = {{52{i[31]}}, i[31:20]};
                   end
            7'h03, 7'h67, 7'h73: begin e.fmt = F_I; e.imm = {{52{i[31]}}, i[31:20]}; end
            7'h23: begin e.fmt = F_S; e.imm = {{52{i[31]}}, i[31:25], i[11:7]}; end
            7'h63: begin e.fmt = F_B; e.imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; end
            7'h37, 7'h17: begin e.fmt = F_U; e.imm = {{32{i[31]}}, i[31:12], 12'd0}; end
            7'h6F: begin e.fmt = F_J; e.imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; end
            7'h33, 7'h3B: e.fmt = F_NONE;
            default: e.ill = 1'b1;
        endcase
        if (i[6:0] == 7'h63 || i[6:0] == 7'h6F || i[6:0] == 7'h17) e.tgt = pc + e.imm;
        return e;
    endfunction

    task automatic check_outputs();
        chk("in_ready", in_ready, sb.size() < 2);
        chk("out_valid", out_valid, sb.size() > 0);
        if (sb.size() > 0) begin
            chk("out_pc", out_pc, sb[0].pc);
            chk("out_instr", out_instr, sb[0].instr);
            chk("out_fmt", out_fmt, sb[0].fmt);
            chk("out_imm", out_imm, sb[0].imm);
            chk("out_target", out_target, sb[0].tgt);
            chk("out_illegal", out_illegal, sb[0].ill);
            if (sb[0].instr == SRAI63) chk("illegal_rv32_srai", r32_out_illegal, 1'b1);
        end
    endtask

    // One cycle: check state at negedge, drive inputs, advance the scoreboard model.
    task automatic cycle(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                         input logic ordy, input logic fl, output logic acc);
        logic rdy_m;
        @(negedge clk);
        check_outputs();
        in_valid = v; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl;
        rdy_m = (sb.size() < 2);
        acc   = v && rdy_m && !fl;
        if (fl) begin
            sb.delete();
        end else begin
            if (sb.size() > 0 && ordy) void'(sb.pop_front());
            if (v && rdy_m) sb.push_back(model_decode(pc, ins));
        end
    endtask

    task automatic send(input logic [63:0] pc, input logic [31:0] ins, input logic ordy);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) cycle(1'b1, pc, ins, ordy, 1'b0, acc);
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int k = 0; k < n; k++) cycle(1'b0, 64'd0, 32'd0, 1'b1, 1'b0, acc);
    endtask

    logic [31:0] dir_ins [12] = '{32'hFE000CE3, 32'h001000EF, 32'h800002B7, SRAI63,
                                  32'h0000007F, 32'hFE112E23, 32'hFFF00513, 32'hFFFFF297,
                                  32'h004080E7, 32'h0010909B, 32'h00B50533, 32'h00B5053B};
    logic [63:0] dir_pc  [12] = '{64'h80000010, 64'h80000000, 64'h80000000, 64'h100,
                                  64'h104, 64'h108, 64'h10C, 64'h1000,
                                  64'h2000, 64'h2004, 64'h2008, 64'h200C};
    logic [6:0]  opc_tab [14] = '{7'h13, 7'h1B, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                                  7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F, 7'h0B};

    initial begin
        logic        acc;
        logic [31:0] r;
        logic [31:0] bp_ins [3];
        int          idx;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_imm", out_imm, 64'd0);
        chk("reset_out_pc", out_pc, 64'd0);
        chk("reset_out_target", out_target, 64'd0);
        reset = 1'b0;

        // Directed decode patterns at full throughput.
        for (int k = 0; k < 12; k++) send(dir_pc[k], dir_ins[k], 1'b1);
        idle(2);

        // Backpressure: A, B fill the stage, C waits until out_ready rises.
        bp_ins[0] = 32'h00100093; bp_ins[1] = 32'h00200113; bp_ins[2] = 32'h00300193;
        idx = 0;
        for (int c = 0; c < 16 && idx < 3; c++) begin
            cycle(1'b1, 64'h3000 + 64'(idx * 4), bp_ins[idx], c >= 4, 1'b0, acc);
            if (acc) idx++;
        end
        if (idx < 3) chk("backpressure_timeout", 64'd0, 64'd1);
        idle(4);

        // Flush with two entries buffered and a coincident input.
        cycle(1'b1, 64'h4000, 32'h00400213, 1'b0, 1'b0, acc);
        cycle(1'b1, 64'h4004, 32'h00500293, 1'b0, 1'b0, acc);
        cycle(1'b1, 64'h4008, 32'h00600313, 1'b0, 1'b0, acc);
        cycle(1'b1, 64'hDEAD0000, 32'h00700393, 1'b0, 1'b1, acc);
        idle(3);

        // Asynchronous reset between clock edges with entries buffered.
        cycle(1'b1, 64'h5000, 32'h00800413, 1'b0, 1'b0, acc);
        cycle(1'b1, 64'h5004, 32'h00900493, 1'b0, 1'b0, acc);
        @(posedge clk);
        #2 reset = 1'b1;
        sb.delete();
        #1;
        chk("async_reset_out_valid", out_valid, 1'b0);
        chk("async_reset_in_ready", in_ready, 1'b1);
        chk("async_reset_out_imm", out_imm, 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        send(64'h6000, 32'hFE000CE3, 1'b1);
        idle(2);

        // Random stream with random valid/ready.
        for (int k = 0; k < 80; k++) begin
            r = $urandom();
            cycle($urandom_range(0, 3) != 0, {$urandom(), $urandom()},
                  {r[31:7], opc_tab[$urandom_range(0, 13)]},
                  $urandom_range(0, 3) != 0, 1'b0, acc);
        end
        for (int k = 0; k < 10 && sb.size() > 0; k++) cycle(1'b0, 64'd0, 32'd0, 1'b1, 1'b0, acc);
        @(negedge clk);
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Registered immediate-extraction stage between fetch and the execute operand mux.
- Accepts raw 32-bit RV32/RV64 instructions with their PC over a valid/ready handshake.
- Classifies each instruction's immediate format and produces the sign/zero-extended immediate plus a precomputed PC-relative target.
- Includes a 2-entry skid buffer, so it runs at full throughput with registered in_ready, and supports pipeline flush.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64
BYPASS_TARGET, 1, 1 = compute out_target; 0 = tie out_target to 0 and drop the adder

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
flush  in  1  discard all buffered entries (branch mispredict/trap)
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept (registered)
in_pc  in  XLEN  PC of instruction
in_instr  in  32  raw instruction
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts
out_pc  out  XLEN  PC passthrough
out_instr  out  32  instruction passthrough
out_fmt  out  3  imm_fmt_t format code
out_imm  out  XLEN  extended immediate
out_target  out  XLEN  pc+imm for B/J/AUIPC, else 0
out_illegal  out  1  opcode not recognised

Behaviour:
- Reset (async, active-high): both entries invalid; out_valid=0; in_ready=1. All data outputs are 0.
- Storage is a main register (drives outputs) plus a skid register. The decode happens combinationally on in_instr before capture, so stored entries are already decoded.
- Accept = in_valid & in_ready. Release = out_valid & out_ready.
- Latency: an accept into an empty stage gives out_valid=1 on the next cycle. Throughput is 1 per cycle while out_ready=1.
- in_ready = !skid_valid (registered).
  - If main is full, out_ready=0 and an accept occurs, the entry goes into skid and in_ready drops next cycle.
  - On release with skid full, skid moves to main and in_ready rises next cycle.
  - Order is strictly FIFO.
- Simultaneous accept and release with skid empty: the new entry replaces main.
- Flush: both entries are invalid next cycle and in_ready=1. An accept in the flush cycle is dropped. Flush has priority over everything except reset.
- Format decode on opcode in_instr[6:0]:
  - 0010011 OP-IMM: funct3 001/101 gives SHAMT, otherwise I.
  - 0011011 OP-IMM-32: funct3 001/101 gives SHAMT5, otherwise I. Illegal when XLEN=32.
  - 0000011 LOAD, 1100111 JALR, 1110011 SYSTEM: I.
  - 0100011: S.
  - 1100011: B.
  - 0110111, 0010111: U.
  - 1101111: J.
  - 0110011, 0111011 (R-type): NONE, legal. 0111011 is illegal when XLEN=32.
  - Anything else: NONE with out_illegal=1.
- Immediates (sign-extended from the top encoded bit to XLEN):
  - I = instr[31:20]
  - S = {instr[31:25], instr[11:7]}
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U = {instr[31:12], 12'b0}
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- SHAMT is zero-extended:
  - XLEN=64: instr[25:20].
  - XLEN=32: instr[24:20]; instr[25]=1 sets illegal.
  - SHAMT5 is zero-extended instr[24:20].
- NONE gives imm 0.
- out_target = (pc + imm) mod 2^XLEN for B, J and AUIPC only. JALR gives 0 (rs1 unknown here).
- The JAL/JALR link increment (+4) is not produced here; execute adds it.

Decomposition:
- Shared package gains:
  - typedef enum logic [2:0] imm_fmt_t {FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SHAMT, FMT_SHAMT5}.
  - Opcode localparams OPC_OP_IMM, OPC_OP_IMM32, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_SYSTEM, OPC_OP, OPC_OP32.
  - A packed struct imm_entry_t {pc, instr, fmt, imm, target, illegal}, parametrised by XLEN via the module.
- One combinational sub-module, imm_extract (instr, pc → fmt, imm, target, illegal). The skid/handshake logic stays in the top module.

Test Plan:
- XLEN=64, pc 0x80000010, instr 0xFE000CE3 (beq -8), out_ready=1 → one cycle later: out_fmt=FMT_B, out_imm=0xFFFFFFFFFFFFFFF8, out_target=0x80000008.
- pc 0x80000000, instr 0x001000EF (jal x1,2048) → FMT_J, imm 0x800, target 0x80000800. instr 0x800002B7 (lui) → FMT_U, imm 0xFFFFFFFF80000000, target 0.
- instr 0x43F0D093 (srai 63) → FMT_SHAMT, imm 0x3F. With XLEN=32, the same instr → out_illegal=1. instr 0x0000007F → FMT_NONE, illegal=1.
- out_ready=0, three back-to-back in_valid entries A,B,C → A and B accepted, in_ready=0 from cycle 2, C held. Then raising out_ready → outputs A,B,C in order, one per cycle, no duplicates.
- Two entries buffered, flush=1 coinciding with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed-cycle input never appears.
- reset asserted asynchronously mid-stream (between clock edges) → out_valid=0 and in_ready=1 immediately. After deassert, the first new accept appears after 1 cycle.
